// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder cell adds WIDTH-bit operands LSB first, one bit per clock.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the 'sub' input port).

module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);
   assign o_s    = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [WIDTH-1:0]   r_a_sr;
   logic [WIDTH-1:0]   r_b_sr;
   logic [WIDTH-1:0]   r_s_sr;
   logic               r_carry;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;

   logic               w_load;
   logic               w_last;
   logic               w_fa_s;
   logic               w_fa_cout;
   logic [WIDTH-1:0]   w_s_next;
   logic [WIDTH-1:0]   w_b_load;
   logic               w_c_load;

   // A new operation is accepted from IDLE or DONE; start during RUN is ignored.
   assign w_load = start && (r_state != S_RUN);
   assign w_last = (r_state == S_RUN) && (r_cnt == LAST);

`ifdef SERIAL_ADDER_SUB_EN
   // Subtraction as a + ~b + 1: cout=1 then means no borrow.
   assign w_b_load = sub ? ~b : b;
   assign w_c_load = sub ? 1'b1 : cin;
`else
   assign w_b_load = b;
   assign w_c_load = cin;
`endif

   full_adder u_fa (
      .i_a    (r_a_sr[0]),
      .i_b    (r_b_sr[0]),
      .i_cin  (r_carry),
      .o_s    (w_fa_s),
      .o_cout (w_fa_cout)
   );

   // New sum bit enters at the MSB; after WIDTH steps bit 0 holds the LSB result.
   assign w_s_next = WIDTH'({w_fa_s, r_s_sr} >> 1);

   // NOTE: the FSM state register and every datapath flop reset asynchronously so a mid-run abort leaves no stale result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
         r_state <= w_next_state;
      end
   end

   // NOTE: next state defaults to the current state so no path leaves it unassigned (no latch).
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_RUN;
         S_RUN:   if (r_cnt == LAST) w_next_state = S_DONE;
         S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_s_sr  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (w_load) begin
         r_a_sr  <= a;
         r_b_sr  <= w_b_load;
         r_s_sr  <= '0;
         r_carry <= w_c_load;
         r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
         r_a_sr  <= r_a_sr >> 1;
         r_b_sr  <= r_b_sr >> 1;
         r_s_sr  <= w_s_next;
         r_carry <= w_fa_cout;
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   // Result registers change only at the final bit step, so they hold through the next operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else if (w_last) begin
         r_sum  <= w_s_next;
         r_cout <= w_fa_cout;
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: cycle-level arithmetic model, per-cycle compare, directed and random stimulus.
// Build with +define+SERIAL_ADDER_SUB_EN to also exercise subtract mode.

module tb_serial_adder_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             sub = 1'b0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int n_cmp = 0;
   int n_err = 0;

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an accepted op yields {cout,sum} = a + b + cin after WIDTH busy cycles.
   int               m_left = 0;
   logic             m_done = 1'b0;
   logic [WIDTH-1:0] m_sum = '0;
   logic             m_cout = 1'b0;
   logic [WIDTH:0]   m_res = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0;
         m_done = 1'b0;
         m_sum  = '0;
         m_cout = 1'b0;
      end else if (m_left > 0) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            {m_cout, m_sum} = m_res;
            m_done = 1'b1;
         end
      end else begin
         m_done = 1'b0;
         if (start) begin
`ifdef SERIAL_ADDER_SUB_EN
            if (sub) m_res = {1'b0, a} + {1'b0, ~b} + 1'b1;
            else     m_res = {1'b0, a} + {1'b0, b} + cin;
`else
            m_res = {1'b0, a} + {1'b0, b} + cin;
`endif
            m_left = WIDTH;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("busy", busy, (m_left > 0));
         check("done", done, m_done);
         check("sum", sum, m_sum);
         check("cout", cout, m_cout);
      end
   end

   // Issues one op; optionally injects an ignored start with a=0x11 at cycle inj_at. Returns cycles to done.
   task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tc,
                        input logic ts, input bit presync, input int inj_at,
                        output int k, output int busy_cnt);
      if (presync) @(negedge clk);
      start = 1'b1; a = ta; b = tb; cin = tc; sub = ts;
      k = 0;
      busy_cnt = 0;
      for (int i = 1; i <= WIDTH + 4; i++) begin
         @(negedge clk);
         start = 1'b0;
         a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
         if (busy) busy_cnt++;
         if (done) begin
            k = i;
            break;
         end
         if (i == inj_at) begin
            start = 1'b1;
            a = 8'h11;
         end
      end
      if (k == 0) check("done_timeout", 0, 1);
   endtask

   int k, bc, dcnt;

   initial begin
      rst_n = 1'b0;
      #23;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, 0, k, bc);
      check("lat_5a3c", k, WIDTH + 1);
      check("busy_cycles", bc, WIDTH);
      check("sum_5a3c", {cout, sum}, 9'h096);

      do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 0, k, bc);
      check("sum_ff01", {cout, sum}, 9'h100);
      do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 0, k, bc);
      check("sum_ffff1", {cout, sum}, 9'h1FF);

      // Back-to-back: start held in the done cycle of the first op.
      do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, 0, k, bc);
      do_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 0, k, bc);
      check("b2b_lat", k, WIDTH + 1);
      check("b2b_sum", {cout, sum}, 9'h003);

      // Mid-run start is ignored and only one done follows.
      do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, 3, k, bc);
      check("midrun_sum", {cout, sum}, 9'h096);
      dcnt = 0;
      for (int i = 0; i < WIDTH + 2; i++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("midrun_extra_done", dcnt, 0);

      // Async reset at RUN cycle 4.
      @(negedge clk);
      start = 1'b1; a = 8'h33; b = 8'h44; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_sum", {cout, sum}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(8'h07, 8'h08, 1'b0, 1'b0, 1'b1, 0, k, bc);
      check("post_rst_sum", {cout, sum}, 9'h00F);

`ifdef SERIAL_ADDER_SUB_EN
      do_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b1, 0, k, bc);
      check("sub_10_01", {cout, sum}, 9'h10F);
      do_op(8'h01, 8'h02, 1'b1, 1'b1, 1'b1, 0, k, bc);
      check("sub_01_02", {cout, sum}, 9'h0FF);
`endif

      // Random traffic: starts at arbitrary times, including during RUN and DONE.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
         cin = 1'($urandom);
         sub = 1'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (WIDTH + 3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller. It time-shares a single full_adder cell to add two WIDTH-bit operands, one bit per clock, LSB first.
- Owns the operand and sum shift registers, the carry flop, a bit counter and a start/busy/done handshake.
- Sits between a requester issuing add operations and the one-bit full_adder datapath. It trades latency for area against a ripple-carry array.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on clk edge, accepted only in IDLE or DONE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  registered final carry, held until next completion

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset (rst_n low, async): state=IDLE; busy=0, done=0, sum=0, cout=0; shift regs, carry flop and counter cleared. Deassertion is synchronous to the next clk edge.
- Reset mid-RUN aborts the operation. No done is produced and sum/cout read 0.
- FSM states:
  - IDLE: start=1 at edge N → load a_sr=a, b_sr=b, carry=cin, cnt=0, s_sr=0 → RUN.
  - RUN: busy=1. Each edge, one full_adder evaluation on (a_sr[0], b_sr[0], carry):
    - a_sr and b_sr shift right;
    - Sout shifts into s_sr MSB (s_sr shifts right);
    - carry ← Cout;
    - cnt ← cnt+1.
  - RUN exit: at the edge where cnt==WIDTH-1, sum ← final shifted value, cout ← Cout of the MSB step, state → DONE.
  - DONE: done=1, busy=0 for exactly one cycle. If start=1 on this edge, the new operation is accepted exactly as from IDLE (back-to-back, no bubble). Otherwise → IDLE.
- Latency: start sampled at edge N. busy is high during cycles N+1..N+WIDTH; done is high for the cycle after edge N+WIDTH. Throughput is WIDTH+1 cycles per op.
- start during RUN is ignored. Operand inputs are don't-care except at the accepting edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No saturation.
- cnt width is $clog2(WIDTH). Counter wrap is never reached because the RUN exit occurs at WIDTH-1.
- sum/cout change only at the RUN-exit edge or on reset; they hold stable through IDLE and RUN of the next op.
- Only one full_adder instance is permitted. No combinational path from inputs to outputs.

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- Defined: adds input port sub (1 bit), captured with start. When sub=1, b_sr loads ~b and carry loads 1 (cin ignored), so the result is a − b. cout=1 means no borrow (a ≥ b unsigned).
- Undefined: no sub port; add only, as above.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start one cycle → busy high 8 cycles, done pulse on the 9th cycle after start edge, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Back-to-back: start held during the done cycle with a=0x01, b=0x02 → second op accepted with no IDLE bubble, next done gives sum=0x03, cout=0. The first result (0x96) stays visible until then.
- start pulsed with a=0x11 mid-RUN → ignored; the in-flight result completes unchanged, and only one done is produced.
- rst_n low at RUN cycle 4 → busy, done, sum, cout = 0 immediately (async). After release, IDLE; the next op a=0x07, b=0x08 → sum=0x0F.
- SERIAL_ADDER_SUB_EN, sub=1: a=0x10, b=0x01 → sum=0x0F, cout=1; a=0x01, b=0x02 → sum=0xFF, cout=0.
